// File: rtl/lutram_fifo_ctrl_pkg.sv
// rtl/lutram_fifo_ctrl_pkg.sv - shared constants and pointer helpers for the LUT-RAM FIFO
package lutram_fifo_pkg;

  localparam int DEPTH = 16;
  localparam int PTR_W = 5;
  localparam int LVL_W = 5;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // Same slot, opposite lap: writer is a full RAM ahead of the reader.
  function automatic logic ptr_full(input logic [PTR_W-1:0] wr, input logic [PTR_W-1:0] rd);
    return (wr[PTR_W-2:0] == rd[PTR_W-2:0]) && (wr[PTR_W-1] != rd[PTR_W-1]);
  endfunction

endpackage

// File: rtl/lutram_fifo_ctrl_if.sv
// rtl/lutram_fifo_ctrl_if.sv - producer/consumer handshake and status bundle of the FIFO
interface lutram_fifo_ctrl_if #(parameter int WIDTH = 8);
  import lutram_fifo_pkg::*;

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [LVL_W-1:0] level;
  logic             almost_full;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level, almost_full
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level, almost_full
  );

endinterface

// File: rtl/lutram_fifo_ctrl_dpram16xw.sv
// rtl/lutram_fifo_ctrl_dpram16xw.sv - 16-deep RAM, sync write / async read, built from 16x4 slices
module dpram16xw
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [3:0]       wad,
  input  logic [WIDTH-1:0] wd,
  input  logic [3:0]       rad,
  output logic [WIDTH-1:0] rd
);

  localparam int NSL = (WIDTH + 3) / 4;

  logic [4*NSL-1:0] wd_pad;
  logic [4*NSL-1:0] rd_pad;

  assign wd_pad = (4*NSL)'(wd);
  assign rd     = rd_pad[WIDTH-1:0];

  for (genvar g = 0; g < NSL; g++) begin : g_slice
    logic [3:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
      if (we) mem[wad] <= wd_pad[4*g +: 4];
    end

    assign rd_pad[4*g +: 4] = mem[rad];
  end

endmodule

// File: rtl/lutram_fifo_ctrl.sv
// rtl/lutram_fifo_ctrl.sv - first-word-fall-through FIFO over a 16-deep LUT RAM plus output register
module lutram_fifo_ctrl
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int AFULL_LVL = 12
) (
  input  logic               CLK,
  input  logic               LSR,
  lutram_fifo_ctrl_if.slave  bus
);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q, level_nxt;
  logic [WIDTH-1:0] out_data_q, ram_rd;
  logic             out_valid_q, almost_full_q;
  logic             ram_empty, ram_full, in_rdy, push, pop, consume;

  // in_ready deliberately ignores out_ready so no comb path crosses the FIFO.
  always_comb begin
    ram_empty = (wr_ptr == rd_ptr);
    ram_full  = ptr_full(wr_ptr, rd_ptr);
    in_rdy    = !ram_full && !LSR && !bus.flush;
    push      = bus.in_valid && in_rdy;
    pop       = !ram_empty && (!out_valid_q || bus.out_ready);
    consume   = out_valid_q && bus.out_ready;
    level_nxt = level_q + LVL_W'(push) - LVL_W'(consume);
  end

  dpram16xw #(.WIDTH(WIDTH)) u_ram (
    .CLK (CLK),
    .we  (push),
    .wad (wr_ptr[3:0]),
    .wd  (bus.in_data),
    .rad (rd_ptr[3:0]),
    .rd  (ram_rd)
  );

  always_ff @(posedge CLK) begin
    if (LSR) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      out_valid_q   <= 1'b0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        out_data_q  <= ram_rd;
        out_valid_q <= 1'b1;
        rd_ptr      <= ptr_inc(rd_ptr);
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
      level_q       <= level_nxt;
      almost_full_q <= (int'(level_nxt) >= AFULL_LVL);
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.level       = level_q;
  assign bus.almost_full = almost_full_q;

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// tb/tb_lutram_fifo_ctrl.sv - directed vector table plus sequence checks for lutram_fifo_ctrl
module tb_lutram_fifo_ctrl;
  import lutram_fifo_pkg::*;

  logic CLK = 1'b0;
  logic LSR;
  always #5 CLK = ~CLK;

  lutram_fifo_ctrl_if #(.WIDTH(8)) bus ();

  lutram_fifo_ctrl #(.WIDTH(8), .AFULL_LVL(12)) dut (
    .CLK (CLK),
    .LSR (LSR),
    .bus (bus)
  );

  typedef struct {
    logic       lsr, fl, iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir, e_ov;
    logic [7:0] e_od;
    logic [4:0] e_lvl;
    logic       e_af;
  } vec_t;

  vec_t       tbl [11];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic fl, input logic lsr);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    bus.flush     = fl;
    LSR           = lsr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One clock against the reference queue; reports handshakes that happened.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                      output logic pu, output logic co);
    int ram_cnt;
    drive(iv, id, ordy, 1'b0, 1'b0);
    #1;
    ram_cnt = q.size() - (bus.out_valid ? 1 : 0);
    chk("in_ready", bus.in_ready, ram_cnt < 16);
    if (bus.out_valid) begin
      if (q.size() == 0) chk("ov_while_empty", bus.out_valid, 0);
      else               chk("head", bus.out_data, q[0]);
    end
    pu = bus.in_valid && bus.in_ready;
    co = bus.out_valid && bus.out_ready;
    if (co && q.size() > 0) void'(q.pop_front());
    if (pu) q.push_back(id);
    tick();
    chk("level", bus.level, q.size());
    chk("almost_full", bus.almost_full, q.size() >= 12);
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    q.delete();
  endtask

  initial begin
    logic pu, co;
    int   n_co, n_pu;
    logic [7:0] d;

    //            lsr fl iv  id     ordy ir ov od     lvl af
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 0, 1, 8'hA5, 0, 1, 0, 8'h00, 1, 0};
    tbl[2]  = '{0, 0, 0, 8'h00, 0, 1, 1, 8'hA5, 1, 0};
    tbl[3]  = '{0, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 0, 0};
    tbl[4]  = '{0, 0, 1, 8'h11, 1, 1, 0, 8'hA5, 1, 0};
    tbl[5]  = '{0, 0, 1, 8'h22, 1, 1, 1, 8'h11, 2, 0};
    tbl[6]  = '{0, 0, 1, 8'h33, 1, 1, 1, 8'h22, 2, 0};
    tbl[7]  = '{0, 0, 0, 8'h00, 1, 1, 1, 8'h33, 1, 0};
    tbl[8]  = '{0, 0, 0, 8'h00, 1, 1, 0, 8'h33, 0, 0};
    tbl[9]  = '{0, 1, 0, 8'h00, 0, 0, 0, 8'h33, 0, 0};
    tbl[10] = '{0, 0, 0, 8'h00, 0, 1, 0, 8'h33, 0, 0};

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl, tbl[i].lsr);
      tick();
      chk($sformatf("v%0d.in_ready", i),  bus.in_ready,    tbl[i].e_ir);
      chk($sformatf("v%0d.out_valid", i), bus.out_valid,   tbl[i].e_ov);
      chk($sformatf("v%0d.out_data", i),  bus.out_data,    tbl[i].e_od);
      chk($sformatf("v%0d.level", i),     bus.level,       tbl[i].e_lvl);
      chk($sformatf("v%0d.afull", i),     bus.almost_full, tbl[i].e_af);
    end

    // Fill to 17, ignored 18th push, then ordered drain.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0, pu, co);
    chk("fill.out_data", bus.out_data, 8'h00);
    chk("fill.level", bus.level, 17);
    step(1'b1, 8'hFF, 1'b0, pu, co);
    chk("fill.ignored", pu, 0);
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, pu, co);
    chk("drain.out_valid", bus.out_valid, 0);

    // Full with both sides active: one-cycle in_ready gap, then one word per cycle.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, pu, co);
    d = 8'h51;
    step(1'b1, d, 1'b1, pu, co);
    chk("thru.first_push_blocked", pu, 0);
    chk("thru.first_pop", co, 1);
    n_co = 0;
    n_pu = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, d, 1'b1, pu, co);
      if (pu) begin d++; n_pu++; end
      if (co) n_co++;
    end
    chk("thru.pushes", n_pu, 30);
    chk("thru.pops", n_co, 30);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, pu, co);

    // Random traffic, first push-biased then pop-biased.
    for (int i = 0; i < 1000; i++) begin
      if (i < 500) step(($urandom % 4) != 0, 8'($urandom), ($urandom % 2) == 0, pu, co);
      else         step(($urandom % 2) == 0, 8'($urandom), ($urandom % 4) != 0, pu, co);
    end

    // Flush at level 9 with push and pop requested.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, pu, co);
    drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush.in_ready_during", bus.in_ready, 0);
    tick();
    q.delete();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush.level", bus.level, 0);
    chk("flush.out_valid", bus.out_valid, 0);
    chk("flush.in_ready", bus.in_ready, 1);
    step(1'b1, 8'h3C, 1'b0, pu, co);
    chk("flush.latency_ov0", bus.out_valid, 0);
    step(1'b0, 8'h00, 1'b0, pu, co);
    chk("flush.ov", bus.out_valid, 1);
    chk("flush.od", bus.out_data, 8'h3C);
    step(1'b0, 8'h00, 1'b1, pu, co);

    // Reset mid-stream at level 5; stale RAM must never surface.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, pu, co);
    drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    #1;
    chk("lsr.in_ready_asserted", bus.in_ready, 0);
    tick();
    chk("lsr.out_data", bus.out_data, 8'h00);
    chk("lsr.out_valid", bus.out_valid, 0);
    chk("lsr.in_ready", bus.in_ready, 0);
    chk("lsr.level", bus.level, 0);
    q.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, pu, co);
      chk("lsr.no_stale", bus.out_valid, 0);
    end
    step(1'b1, 8'h77, 1'b0, pu, co);
    step(1'b0, 8'h00, 1'b0, pu, co);
    chk("lsr.new_ov", bus.out_valid, 1);
    chk("lsr.new_od", bus.out_data, 8'h77);
    step(1'b0, 8'h00, 1'b1, pu, co);
    chk("lsr.final_empty", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
